// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: digit/segment widths
// and the active-high hex glyph table, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    // Entry 15 is listed first so that SEG_TABLE[v] returns the glyph for v.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder, active-high outputs.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    output logic [SEG_W-1:0]   segs
);

    assign segs = SEG_TABLE[value];

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Multiplexed seven-segment display scanner: snapshot register, refresh
// prescaler, slot index, leading-zero blanking and registered pin drive.
module bcd_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    input  logic                            blank_lz,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [SEG_W-1:0]                seg,
    output logic                            dp,
    output logic [$clog2(NUM_DIGITS)-1:0]   scan_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic AN_INV  = (ANODE_ACTIVE_LOW != 0);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]              cnt;
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              idx_next;
    logic                          tick;
    logic [DIGIT_W*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]         snap_dp;
    logic [NUM_DIGITS-1:0]         blank_mask;
    logic                          zero_run;
    logic [NUM_DIGITS-1:0]         an_hot;
    logic [DIGIT_W-1:0]            digit_sel;
    logic                          dp_sel;
    logic                          blank_sel;
    logic [SEG_W-1:0]              dec_segs;

    assign tick = enable && (cnt == LAST_CNT);

    // Refresh prescaler: counts only while scanning, frozen when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

    // Next slot index; advances on tick and wraps after the last digit.
    always_comb begin
        idx_next = idx;
        if (tick) begin
            idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Slot index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else begin
            idx <= idx_next;
        end
    end

    // Snapshot of the displayed value, captured on load regardless of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
        end else if (load) begin
            snap_digits <= digits_in;
            snap_dp     <= dp_in;
        end
    end

    // Leading-zero mask: digit i blanks when it and every digit above it are zero.
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (snap_digits[i*DIGIT_W +: DIGIT_W] == '0);
            blank_mask[i] = blank_lz & zero_run;
        end
    end

    // Select the digit, dp and blank bit for the slot being driven next cycle.
    // The current snapshot is used, so a load coinciding with a tick shows up
    // one update later.
    always_comb begin
        an_hot    = '0;
        digit_sel = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_next) begin
                an_hot[i] = 1'b1;
                digit_sel = snap_digits[i*DIGIT_W +: DIGIT_W];
                dp_sel    = snap_dp[i];
                blank_sel = blank_mask[i];
            end
        end
    end

    seg7_decode u_decode (
        .value (digit_sel),
        .segs  (dec_segs)
    );

    // Registered pin drive, refreshed every cycle; dark while disabled or in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an       <= {NUM_DIGITS{AN_INV}};
            seg      <= {SEG_W{SEG_INV}};
            dp       <= SEG_INV;
            scan_idx <= '0;
        end else begin
            scan_idx <= idx_next;
            if (enable) begin
                an  <= an_hot ^ {NUM_DIGITS{AN_INV}};
                seg <= (blank_sel ? '0 : dec_segs) ^ {SEG_W{SEG_INV}};
                dp  <= dp_sel ^ SEG_INV;
            end else begin
                an  <= {NUM_DIGITS{AN_INV}};
                seg <= {SEG_W{SEG_INV}};
                dp  <= SEG_INV;
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl (4 digits, divide-by-4, active-low drive)
// with a cycle-level behavioural model checked every falling edge.
module tb_bcd_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  scan_idx;

    int vectors     = 0;
    int miscompares = 0;
    bit model_on    = 1'b0;

    bcd_scan_ctrl #(
        .NUM_DIGITS       (N),
        .REFRESH_DIV      (DIV),
        .ANODE_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .scan_idx  (scan_idx)
    );

    always #5 clk = ~clk;

    // Hex glyphs, active-high, index = value.
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state and expected pin values.
    int          m_cnt;
    int          m_idx;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [1:0]  e_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: slot = number of elapsed refresh periods mod N,
    // displayed glyph comes from the snapshot held before this edge.
    always @(posedge clk or posedge rst) begin : model
        int          nidx;
        int          val;
        logic [15:0] upper;
        bit          blank;
        if (rst) begin
            m_cnt  <= 0;
            m_idx  <= 0;
            m_snap <= '0;
            m_dp   <= '0;
            e_an   <= 4'hF;
            e_seg  <= 7'h7F;
            e_dp   <= 1'b1;
            e_idx  <= 2'd0;
        end else begin
            nidx = m_idx;
            if (enable && m_cnt == DIV - 1) nidx = (m_idx + 1) % N;
            if (enable) m_cnt <= (m_cnt + 1) % DIV;
            m_idx <= nidx;
            e_idx <= nidx[1:0];
            upper = m_snap >> (4 * nidx);
            val   = int'(upper & 16'hF);
            blank = blank_lz && (nidx > 0) && (upper == 16'h0);
            if (enable) begin
                e_an  <= ~(4'b0001 << nidx);
                e_seg <= blank ? 7'h7F : ~hex_tab[val];
                e_dp  <= ~m_dp[nidx];
            end else begin
                e_an  <= 4'hF;
                e_seg <= 7'h7F;
                e_dp  <= 1'b1;
            end
            if (load) begin
                m_snap <= digits_in;
                m_dp   <= dp_in;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
            chk("dp", dp, e_dp);
            chk("scan_idx", scan_idx, e_idx);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to the first cycle in which an becomes target.
    task automatic wait_an(input logic [3:0] target);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64; k++) begin
            prev = an;
            cyc(1);
            if (an == target && prev != target) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_an: an=%b never became %b", an, target);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        digits_in = '0; dp_in = '0; blank_lz = 1'b0;
        cyc(2);
        model_on = 1'b1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_idx", scan_idx, 2'd0);

        // Scan sequence from reset release
        rst = 1'b0; enable = 1'b1;
        cyc(1);  chk("seq_s0", an, 4'b1110); chk("seq_s0_seg", seg, 7'h40);
        cyc(3);  chk("seq_s1", an, 4'b1101);
        cyc(3);  chk("seq_s1_hold", an, 4'b1101);
        cyc(1);  chk("seq_s2", an, 4'b1011);
        cyc(4);  chk("seq_s3", an, 4'b0111);
        cyc(4);  chk("seq_wrap", an, 4'b1110);

        // 1234 with dp on digit 2
        load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100;
        cyc(1);  load = 1'b0;
        cyc(1);  chk("ld_s0_seg", seg, 7'h19); chk("ld_s0_dp", dp, 1'b1);
        wait_an(4'b1011); chk("ld_s2_seg", seg, 7'h24); chk("ld_s2_dp", dp, 1'b0);
        wait_an(4'b0111); chk("ld_s3_seg", seg, 7'h79); chk("ld_s3_dp", dp, 1'b1);

        // 0005 with and without leading-zero blanking
        load = 1'b1; digits_in = 16'h0005; dp_in = 4'b0000; blank_lz = 1'b1;
        cyc(1);  load = 1'b0;
        wait_an(4'b1110); chk("lz_s0", seg, 7'h12);
        wait_an(4'b1101); chk("lz_s1", seg, 7'h7F);
        wait_an(4'b1011); chk("lz_s2", seg, 7'h7F);
        wait_an(4'b0111); chk("lz_s3", seg, 7'h7F);
        blank_lz = 1'b0;
        wait_an(4'b1110); chk("nolz_s0", seg, 7'h12);
        wait_an(4'b1101); chk("nolz_s1", seg, 7'h40);
        wait_an(4'b0111); chk("nolz_s3", seg, 7'h40);

        // All-zero snapshot with blanking: only slot 0 lit
        load = 1'b1; digits_in = 16'h0000; blank_lz = 1'b1;
        cyc(1);  load = 1'b0;
        wait_an(4'b1110); chk("z_s0", seg, 7'h40);
        wait_an(4'b1101); chk("z_s1", seg, 7'h7F);
        wait_an(4'b0111); chk("z_s3", seg, 7'h7F);

        // Load coinciding with a tick
        blank_lz = 1'b0;
        load = 1'b1; digits_in = 16'h4321;
        cyc(1);  load = 1'b0;
        wait_an(4'b1110);
        cyc(3);
        load = 1'b1; digits_in = 16'h9876;
        cyc(1);  load = 1'b0;
        chk("lt_an", an, 4'b1101); chk("lt_old", seg, 7'h24);
        cyc(1);  chk("lt_refresh", seg, 7'h78);
        wait_an(4'b1011); chk("lt_new", seg, 7'h00);

        // Enable dropped for 10 cycles at prescaler=2
        wait_an(4'b1110);
        cyc(2);  enable = 1'b0;
        cyc(1);  chk("dis_an", an, 4'hF); chk("dis_seg", seg, 7'h7F);
                 chk("dis_dp", dp, 1'b1); chk("dis_idx", scan_idx, 2'd0);
        cyc(9);  enable = 1'b1;
        cyc(1);  chk("ren_s0", an, 4'b1110);
        cyc(1);  chk("ren_s1", an, 4'b1101);

        // Asynchronous reset mid-scan, then a full period before the first tick
        #2 rst = 1'b1;
        #1 chk("arst_an", an, 4'hF); chk("arst_seg", seg, 7'h7F);
           chk("arst_dp", dp, 1'b1); chk("arst_idx", scan_idx, 2'd0);
        cyc(2);  rst = 1'b0;
        cyc(1);  chk("rel_s0", an, 4'b1110); chk("rel_seg", seg, 7'h40);
        cyc(2);  chk("rel_hold", an, 4'b1110);
        cyc(1);  chk("rel_s1", an, 4'b1101);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
